// File: rtl/instr_loader.sv
// Instruction memory loader: streams 32-bit words into byte memory MSB first,
// with an optional all-zero halt word after the last word of a program.
module instr_loader #(
    parameter bit          APPEND_HALT = 1'b1,
    parameter logic [18:0] TOP_ADDR    = 19'h7FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] base_addr,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WR,
        S_HALT,
        S_FIN
    } state_e;

    state_e      state_q;
    // One spare bit so ptr+4 past the top never aliases back to address 0
    logic [19:0] ptr_q;
    logic [31:0] data_q;
    logic        last_q;
    logic [1:0]  idx_q;
    logic [15:0] word_count_q;
    logic        err_q;
    logic        done_q;
    logic        busy_q;
    logic        word_ready_q;
    logic        mem_we_q;
    logic [18:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;

    logic [19:0] lim_d;
    logic [19:0] ptr_nx_d;
    logic        ovf_cur_d;
    logic        ovf_nxt_d;
    logic [18:0] byte_addr_d;
    logic [31:0] shifted_d;
    logic [7:0]  next_byte_d;
    logic [15:0] wc_inc_d;
    logic [1:0]  idx_nx_d;

    assign lim_d       = {1'b0, TOP_ADDR};
    assign ptr_nx_d    = ptr_q + 20'd4;
    assign ovf_cur_d   = (ptr_q + 20'd3) > lim_d;
    assign ovf_nxt_d   = (ptr_nx_d + 20'd3) > lim_d;
    assign idx_nx_d    = idx_q + 2'd1;
    assign byte_addr_d = ptr_q[18:0] + {17'd0, idx_nx_d};
    assign shifted_d   = data_q << {idx_nx_d, 3'b000};
    assign next_byte_d = shifted_d[31:24];
    assign wc_inc_d    = (word_count_q == 16'hFFFF) ? word_count_q
                                                     : word_count_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            word_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_WAIT;
                        ptr_q        <= {1'b0, base_addr};
                        word_count_q <= '0;
                        err_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        word_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (word_valid) begin
                        data_q       <= word_data;
                        last_q       <= word_last;
                        word_ready_q <= 1'b0;
                        if (ovf_cur_d) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= S_WR;
                            idx_q       <= 2'd0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ptr_q[18:0];
                            mem_wdata_q <= word_data[31:24];
                        end
                    end
                end
                S_WR: begin
                    if (idx_q != 2'd3) begin
                        idx_q       <= idx_nx_d;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= byte_addr_d;
                        mem_wdata_q <= next_byte_d;
                    end else begin
                        ptr_q        <= ptr_nx_d;
                        word_count_q <= wc_inc_d;
                        idx_q        <= 2'd0;
                        if (!last_q) begin
                            state_q      <= S_WAIT;
                            word_ready_q <= 1'b1;
                        end else if (!APPEND_HALT) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else if (ovf_nxt_d) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_HALT;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= ptr_nx_d[18:0];
                        end
                    end
                end
                S_HALT: begin
                    if (idx_q != 2'd3) begin
                        idx_q      <= idx_nx_d;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= byte_addr_d;
                    end else begin
                        idx_q   <= 2'd0;
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign word_ready = word_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule
